// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: shares the ROB result-write port among NUM_SRC
// execution-unit result sources. Each source has a one-entry holding buffer;
// a round-robin pointer picks one buffered result per cycle and drives it
// onto a registered broadcast port (tag + data + source index).
module cdb_arbiter #(
    parameter int                   NUM_SRC     = 4,
    parameter int                   TAG_WIDTH   = 5,
    parameter int                   DATA_WIDTH  = 32,
    parameter logic [TAG_WIDTH-1:0] TAG_INVALID = {TAG_WIDTH{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          out_valid,
    output logic [TAG_WIDTH-1:0]          out_tag,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_SRC)-1:0]    out_src
);

    localparam int SRC_W = $clog2(NUM_SRC);

    // Holding stage (one entry per source)
    logic [NUM_SRC-1:0]    hold_valid_p0;
    logic [TAG_WIDTH-1:0]  hold_tag_p0  [NUM_SRC];
    logic [DATA_WIDTH-1:0] hold_data_p0 [NUM_SRC];
    logic [SRC_W-1:0]      rr_ptr;

    // Broadcast stage
    logic                  out_valid_p1;
    logic [TAG_WIDTH-1:0]  out_tag_p1;
    logic [DATA_WIDTH-1:0] out_data_p1;
    logic [SRC_W-1:0]      out_src_p1;

    logic                  grant_any;
    logic [SRC_W-1:0]      grant_idx;
    logic [SRC_W-1:0]      next_ptr;
    logic [NUM_SRC-1:0]    granted;
    logic [NUM_SRC-1:0]    load;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_SRC
    always_comb begin
        logic [SRC_W:0]   idx_w;
        logic [SRC_W-1:0] idx;
        grant_any = 1'b0;
        grant_idx = '0;
        granted   = '0;
        idx_w     = '0;
        idx       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx_w = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (idx_w >= (SRC_W+1)'(NUM_SRC))
                idx_w = idx_w - (SRC_W+1)'(NUM_SRC);
            idx = idx_w[SRC_W-1:0];
            if (!grant_any && hold_valid_p0[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (grant_any)
            granted[grant_idx] = 1'b1;
        if (grant_idx == SRC_W'(NUM_SRC - 1))
            next_ptr = '0;
        else
            next_ptr = grant_idx + 1'b1;
    end

    // Ready depends only on registered state; a granted slot can be refilled
    // on the same edge it drains. Invalid-tag transfers are accepted but not held.
    always_comb begin
        src_ready = '0;
        load      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = rst && !flush && (!hold_valid_p0[i] || granted[i]);
            load[i]      = src_valid[i] && src_ready[i] &&
                           (src_tag[i*TAG_WIDTH +: TAG_WIDTH] != TAG_INVALID);
        end
    end

    // Holding-buffer occupancy and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid_p0 <= '0;
            rr_ptr        <= '0;
        end else if (flush) begin
            hold_valid_p0 <= '0;
            rr_ptr        <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (load[i])
                    hold_valid_p0[i] <= 1'b1;
                else if (granted[i])
                    hold_valid_p0[i] <= 1'b0;
            end
            if (grant_any)
                rr_ptr <= next_ptr;
        end
    end

    // Holding-buffer payload capture (qualified by occupancy, so no reset)
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (load[i]) begin
                hold_tag_p0[i]  <= src_tag[i*TAG_WIDTH +: TAG_WIDTH];
                hold_data_p0[i] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Broadcast register; idle cycles present a deterministic invalid tag and zero data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_p1 <= 1'b0;
            out_tag_p1   <= TAG_INVALID;
            out_data_p1  <= '0;
            out_src_p1   <= '0;
        end else if (flush || !grant_any) begin
            out_valid_p1 <= 1'b0;
            out_tag_p1   <= TAG_INVALID;
            out_data_p1  <= '0;
        end else begin
            out_valid_p1 <= 1'b1;
            out_tag_p1   <= hold_tag_p0[grant_idx];
            out_data_p1  <= hold_data_p0[grant_idx];
            out_src_p1   <= grant_idx;
        end
    end

    assign out_valid = out_valid_p1;
    assign out_tag   = out_tag_p1;
    assign out_data  = out_data_p1;
    assign out_src   = out_src_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (NUM_SRC=4, TAG_WIDTH=5, DATA_WIDTH=32).
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   src_valid;
    logic [19:0]  src_tag;
    logic [127:0] src_data;
    logic [3:0]   src_ready;
    logic         out_valid;
    logic [4:0]   out_tag;
    logic [31:0]  out_data;
    logic [1:0]   out_src;

    int checks = 0;
    int fails  = 0;

    cdb_arbiter #(
        .NUM_SRC(4), .TAG_WIDTH(5), .DATA_WIDTH(32), .TAG_INVALID(5'h1F)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_ready(src_ready),
        .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic set_src(input int i, input logic v, input logic [4:0] t, input logic [31:0] d);
        src_valid[i]       = v;
        src_tag[i*5 +: 5]  = t;
        src_data[i*32 +: 32] = d;
    endtask

    task automatic clear_src();
        src_valid = '0;
        src_tag   = '0;
        src_data  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        set_src(0, 1, 5'd1, 32'h1); set_src(1, 1, 5'd2, 32'h2);
        set_src(2, 1, 5'd3, 32'h3); set_src(3, 1, 5'd4, 32'h4);
        step(); step(); step();
        checks++; if (src_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want %b", src_ready, 4'b0000); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_tag !== 5'h1F) begin fails++; $display("FAIL reset_out_tag got %h want 1f", out_tag); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_src !== 2'd0) begin fails++; $display("FAIL reset_out_src got %0d want 0", out_src); end
        rst = 1'b1;
        clear_src();
        #1;
        checks++; if (src_ready !== 4'b1111) begin fails++; $display("FAIL reset_release_ready got %b want 1111", src_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
    endtask

    task automatic test_contention();
        set_src(0, 1, 5'd1, 32'h11); set_src(1, 1, 5'd2, 32'h22);
        set_src(2, 1, 5'd3, 32'h33); set_src(3, 1, 5'd4, 32'h44);
        #1;
        checks++; if (src_ready !== 4'b1111) begin fails++; $display("FAIL cont_ready0 got %b want 1111", src_ready); end
        step();
        clear_src();
        #1;
        checks++; if (src_ready !== 4'b0001) begin fails++; $display("FAIL cont_ready1 got %b want 0001", src_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL cont_valid_early got %b want 0", out_valid); end
        step();
        checks++; if ({out_valid, out_tag, out_data, out_src} !== {1'b1, 5'd1, 32'h11, 2'd0}) begin fails++; $display("FAIL cont_out0 got v=%b t=%0d d=%h s=%0d want v=1 t=1 d=11 s=0", out_valid, out_tag, out_data, out_src); end
        checks++; if (src_ready !== 4'b0011) begin fails++; $display("FAIL cont_ready2 got %b want 0011", src_ready); end
        step();
        checks++; if ({out_valid, out_tag, out_data, out_src} !== {1'b1, 5'd2, 32'h22, 2'd1}) begin fails++; $display("FAIL cont_out1 got v=%b t=%0d d=%h s=%0d want v=1 t=2 d=22 s=1", out_valid, out_tag, out_data, out_src); end
        checks++; if (src_ready !== 4'b0111) begin fails++; $display("FAIL cont_ready3 got %b want 0111", src_ready); end
        step();
        checks++; if ({out_valid, out_tag, out_data, out_src} !== {1'b1, 5'd3, 32'h33, 2'd2}) begin fails++; $display("FAIL cont_out2 got v=%b t=%0d d=%h s=%0d want v=1 t=3 d=33 s=2", out_valid, out_tag, out_data, out_src); end
        checks++; if (src_ready !== 4'b1111) begin fails++; $display("FAIL cont_ready4 got %b want 1111", src_ready); end
        step();
        checks++; if ({out_valid, out_tag, out_data, out_src} !== {1'b1, 5'd4, 32'h44, 2'd3}) begin fails++; $display("FAIL cont_out3 got v=%b t=%0d d=%h s=%0d want v=1 t=4 d=44 s=3", out_valid, out_tag, out_data, out_src); end
        step();
        checks++; if (out_valid !== 1'b0 || out_tag !== 5'h1F) begin fails++; $display("FAIL cont_drain got v=%b t=%h want v=0 t=1f", out_valid, out_tag); end
    endtask

    task automatic test_wrap();
        set_src(2, 1, 5'd7, 32'h70);
        step();
        clear_src();
        set_src(0, 1, 5'd8, 32'h80); set_src(3, 1, 5'd9, 32'h90);
        step();
        clear_src();
        checks++; if ({out_valid, out_tag, out_src} !== {1'b1, 5'd7, 2'd2}) begin fails++; $display("FAIL wrap_src2 got v=%b t=%0d s=%0d want v=1 t=7 s=2", out_valid, out_tag, out_src); end
        step();
        checks++; if ({out_valid, out_tag, out_data, out_src} !== {1'b1, 5'd9, 32'h90, 2'd3}) begin fails++; $display("FAIL wrap_src3_first got v=%b t=%0d d=%h s=%0d want v=1 t=9 d=90 s=3", out_valid, out_tag, out_data, out_src); end
        step();
        checks++; if ({out_valid, out_tag, out_data, out_src} !== {1'b1, 5'd8, 32'h80, 2'd0}) begin fails++; $display("FAIL wrap_src0_second got v=%b t=%0d d=%h s=%0d want v=1 t=8 d=80 s=0", out_valid, out_tag, out_data, out_src); end
        set_src(0, 1, 5'd10, 32'hA0); set_src(1, 1, 5'd11, 32'hB0);
        step();
        clear_src();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL wrap_gap got %b want 0", out_valid); end
        step();
        checks++; if ({out_valid, out_tag, out_src} !== {1'b1, 5'd11, 2'd1}) begin fails++; $display("FAIL wrap_ptr1_src1 got v=%b t=%0d s=%0d want v=1 t=11 s=1", out_valid, out_tag, out_src); end
        step();
        checks++; if ({out_valid, out_tag, out_src} !== {1'b1, 5'd10, 2'd0}) begin fails++; $display("FAIL wrap_ptr1_src0 got v=%b t=%0d s=%0d want v=1 t=10 s=0", out_valid, out_tag, out_src); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL wrap_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        set_src(0, 1, 5'd3, 32'hA);
        #1;
        checks++; if (src_ready[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready_a got %b want 1", src_ready[0]); end
        step();
        set_src(0, 1, 5'd4, 32'hB);
        #1;
        checks++; if (src_ready[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready_b got %b want 1", src_ready[0]); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_latency got %b want 0", out_valid); end
        step();
        checks++; if ({out_valid, out_tag, out_data, out_src} !== {1'b1, 5'd3, 32'hA, 2'd0}) begin fails++; $display("FAIL b2b_out0 got v=%b t=%0d d=%h s=%0d want v=1 t=3 d=a s=0", out_valid, out_tag, out_data, out_src); end
        set_src(0, 1, 5'd5, 32'hC);
        #1;
        checks++; if (src_ready[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready_c got %b want 1", src_ready[0]); end
        step();
        clear_src();
        checks++; if ({out_valid, out_tag, out_data, out_src} !== {1'b1, 5'd4, 32'hB, 2'd0}) begin fails++; $display("FAIL b2b_out1 got v=%b t=%0d d=%h s=%0d want v=1 t=4 d=b s=0", out_valid, out_tag, out_data, out_src); end
        step();
        checks++; if ({out_valid, out_tag, out_data, out_src} !== {1'b1, 5'd5, 32'hC, 2'd0}) begin fails++; $display("FAIL b2b_out2 got v=%b t=%0d d=%h s=%0d want v=1 t=5 d=c s=0", out_valid, out_tag, out_data, out_src); end
        step();
        checks++; if ({out_valid, out_tag, out_data} !== {1'b0, 5'h1F, 32'h0}) begin fails++; $display("FAIL b2b_idle got v=%b t=%h d=%h want v=0 t=1f d=0", out_valid, out_tag, out_data); end
    endtask

    task automatic test_invalid_tag();
        set_src(1, 1, 5'h1F, 32'hDEAD);
        #1;
        checks++; if (src_ready[1] !== 1'b1) begin fails++; $display("FAIL inv_ready got %b want 1", src_ready[1]); end
        step();
        clear_src();
        #1;
        checks++; if (src_ready !== 4'b1111) begin fails++; $display("FAIL inv_not_held got %b want 1111", src_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (out_valid !== 1'b0 || out_tag !== 5'h1F) begin fails++; $display("FAIL inv_no_out cyc%0d got v=%b t=%h want v=0 t=1f", c, out_valid, out_tag); end
        end
    endtask

    task automatic test_flush();
        set_src(0, 1, 5'h0A, 32'h100); set_src(1, 1, 5'h0B, 32'h200);
        set_src(2, 1, 5'h0C, 32'h300);
        step();
        clear_src();
        step();
        checks++; if ({out_valid, out_tag, out_data, out_src} !== {1'b1, 5'h0B, 32'h200, 2'd1}) begin fails++; $display("FAIL flush_pre got v=%b t=%h d=%h s=%0d want v=1 t=0b d=200 s=1", out_valid, out_tag, out_data, out_src); end
        flush = 1'b1;
        set_src(3, 1, 5'h0D, 32'h400);
        #1;
        checks++; if (src_ready !== 4'b0000) begin fails++; $display("FAIL flush_ready got %b want 0000", src_ready); end
        step();
        flush = 1'b0;
        clear_src();
        checks++; if (out_valid !== 1'b0 || out_tag !== 5'h1F) begin fails++; $display("FAIL flush_out got v=%b t=%h want v=0 t=1f", out_valid, out_tag); end
        #1;
        checks++; if (src_ready !== 4'b1111) begin fails++; $display("FAIL flush_cleared got %b want 1111", src_ready); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_ghost cyc%0d got v=%b t=%h want v=0", c, out_valid, out_tag); end
        end
    endtask

    task automatic test_reset_midstream();
        set_src(0, 1, 5'd1, 32'h1); set_src(1, 1, 5'd2, 32'h2);
        step();
        clear_src();
        step();
        checks++; if ({out_valid, out_tag, out_src} !== {1'b1, 5'd1, 2'd0}) begin fails++; $display("FAIL mid_pre got v=%b t=%0d s=%0d want v=1 t=1 s=0", out_valid, out_tag, out_src); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_tag !== 5'h1F) begin fails++; $display("FAIL mid_async got v=%b t=%h want v=0 t=1f", out_valid, out_tag); end
        checks++; if (src_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready got %b want 0000", src_ready); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (src_ready !== 4'b1111) begin fails++; $display("FAIL mid_release_ready got %b want 1111", src_ready); end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_dropped cyc%0d got v=%b t=%0d want v=0", c, out_valid, out_tag); end
        end
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        clear_src();
        test_reset();
        test_contention();
        test_wrap();
        test_back_to_back();
        test_invalid_tag();
        test_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
